// File: rtl/shared_bus_pkg.sv
// rtl/shared_bus_pkg.sv - shared types, widths and the round-robin pick helper for the shared bus arbiter
//
// Contents:
//   state_t      - arbiter FSM states (TURN used only with SHARED_BUS_TURNAROUND_EN)
//   pick_t       - result of a round-robin search: found flag + winner index
//   owner_width  - width of an owner index for a given master count
//   rr_pick      - cyclic first-set search starting at a pointer
package shared_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Upper bound on masters handled by rr_pick; request vectors are zero-extended to it.
    localparam int MAX_MASTERS = 32;
    localparam int PICK_W      = 5;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requesting index at or after ptr, wrapping at n. ptr must be < n.
    function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                      input int                     n,
                                      input int                     ptr);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!p.found && req[idx]) begin
                    p.found = 1'b1;
                    p.idx   = idx[PICK_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational cyclic-priority pick from a request vector and a rotating pointer
//
// Ports:
//   req    in  [N-1:0]  request vector
//   ptr    in  [W-1:0]  index with highest priority this cycle
//   winner out [W-1:0]  first requesting index at or after ptr (cyclic); 0 when none
//   found  out          at least one request is set
module rr_arbiter
    import shared_bus_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [MAX_MASTERS-1:0] req_ext;
    pick_t                  pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, N, int'(ptr));
        found          = pick.found;
        winner         = W'(pick.idx);
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - round-robin owner arbitration with max-hold release driving a registered shared bus
//
// Optional feature macro: SHARED_BUS_TURNAROUND_EN (one idle TURN cycle on every release).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [N_MASTERS-1:0]         per-master level-held request
//   wdata      in   [N_MASTERS*DATA_W-1:0]  master i drives bits [i*DATA_W +: DATA_W]
//   gnt        out  [N_MASTERS-1:0]         one-hot grant, zero when no owner
//   bus_owner  out  [$clog2(N_MASTERS)-1:0] current owner index, valid while |gnt
//   bus_data   out  [DATA_W-1:0]            registered bus value (lags gnt by one cycle)
//   bus_valid  out                          bus_data carries owner data
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_HOLD  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS*DATA_W-1:0]   wdata,
    output logic [N_MASTERS-1:0]          gnt,
    output logic [$clog2(N_MASTERS)-1:0]  bus_owner,
    output logic [DATA_W-1:0]             bus_data,
    output logic                          bus_valid
);

    localparam int OW = owner_width(N_MASTERS);

    // With MAX_HOLD=0 the counter only needs to saturate, so a small width is enough.
    localparam int HOLD_W = (MAX_HOLD == 0) ? 2 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [OW-1:0]     LAST_IDX   = OW'(N_MASTERS - 1);

    state_t              state_q, state_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_MASTERS-1:0] gnt_d;
    logic [OW-1:0]       owner_d;

    logic [OW-1:0]       win;
    logic                win_found;
    logic                do_grant;
    logic                owner_req;
    logic                hold_ok;
    logic                bus_hit;
    logic [DATA_W-1:0]   owner_wdata;

    rr_arbiter #(
        .N (N_MASTERS),
        .W (OW)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (rr_ptr_q),
        .winner (win),
        .found  (win_found)
    );

    assign owner_req   = req[bus_owner];
    assign hold_ok     = (MAX_HOLD == 0) || (hold_q < HOLD_LIMIT);
    assign bus_hit     = gnt[bus_owner] && req[bus_owner];
    assign owner_wdata = wdata[bus_owner*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt;
        owner_d  = bus_owner;
        do_grant = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d    = '0;
                do_grant = win_found;
            end
            GRANT: begin
                if (owner_req && hold_ok) begin
                    if (hold_q != {HOLD_W{1'b1}}) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
`ifdef SHARED_BUS_TURNAROUND_EN
                    state_d = TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
`else
                    // Back-to-back handover; rr_ptr already points past the
                    // owner, so a forced-released owner only wins when alone.
                    state_d  = IDLE;
                    gnt_d    = '0;
                    hold_d   = '0;
                    do_grant = win_found;
`endif
                end
            end
`ifdef SHARED_BUS_TURNAROUND_EN
            TURN: begin
                state_d  = IDLE;
                gnt_d    = '0;
                do_grant = win_found;
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        if (do_grant) begin
            state_d  = GRANT;
            gnt_d    = N_MASTERS'(1) << win;
            owner_d  = win;
            hold_d   = HOLD_W'(1);
            rr_ptr_d = (win == LAST_IDX) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            gnt       <= '0;
            bus_owner <= '0;
            bus_data  <= '0;
            bus_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            gnt       <= gnt_d;
            bus_owner <= owner_d;
            // The bus follows the grant held during this cycle, hence the one-cycle lag.
            if (bus_hit) begin
                bus_data  <= owner_wdata;
                bus_valid <= 1'b1;
            end else begin
                bus_data  <= '0;
                bus_valid <= 1'b0;
            end
        end
    end

endmodule
